// File: rtl/profiler_pkg.sv
// Shared types and helpers for the stage profiler and its channels.
package profiler_pkg;

  // Per-channel measurement state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  // Default stop word.
  localparam logic [31:0] DEFAULT_SENTINEL = 32'h7fffffff;

  // Increments value and holds at all-ones of the given width (1..64).
  // Callers cast the result back to their own counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : value + 64'd1;
  endfunction

endpackage

// File: rtl/profiler_channel.sv
// One profiler channel: IDLE/RUN/DONE FSM, saturating cycle counter,
// sticky overflow flag and sentinel comparator on its monitored bus.
module profiler_channel
  import profiler_pkg::*;
#(
  parameter int                CNT_W    = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SENTINEL = DATA_W'(DEFAULT_SENTINEL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,      // restart the whole measurement
  input  logic              start_arm,  // this channel runs on start
  input  logic              clear,
  input  logic              chain_arm,  // hand-off from the previous channel
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              stop        // stop event this cycle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ch_state_e        state, state_n;
  logic [CNT_W-1:0] count_n;
  logic             overflow_n;

  // Next-state, counter and overflow decode; start beats clear.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_n    = state;
    count_n    = count;
    overflow_n = overflow;
    stop       = (state == RUN) && rvalid && (rdata == SENTINEL);
    if (start) begin
      state_n    = start_arm ? RUN : IDLE;
      count_n    = '0;
      overflow_n = 1'b0;
    end else if (clear) begin
      state_n    = IDLE;
      count_n    = '0;
      overflow_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (chain_arm) begin
            state_n = RUN;
            count_n = '0;
          end
        end
        RUN: begin
          count_n = CNT_W'(sat_inc(64'(count), CNT_W));
          if (count == CNT_MAX) overflow_n = 1'b1;
          if (stop) state_n = DONE;
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counter and overflow registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      overflow <= overflow_n;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: rtl/stage_profiler.sv
// Multi-channel cycle profiler: per-channel arm-to-sentinel counts,
// chained or parallel arming, and an end-to-end saturating total.
module stage_profiler
  import profiler_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                CNT_W    = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] SENTINEL = DATA_W'(DEFAULT_SENTINEL),
  parameter bit                CHAIN    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic [NUM_CH*DATA_W-1:0] rdata,
  input  logic [NUM_CH-1:0]        rvalid,
  output logic [NUM_CH*CNT_W-1:0]  count,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     all_done,
  output logic [CNT_W-1:0]         total
);

  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] chain_src;
  logic [NUM_CH-1:0] arm_q;
  logic              total_en;

  // Channel k's hand-off source is channel k-1's stop; channel 0 has none.
  always_comb begin
    chain_src = CHAIN ? NUM_CH'({stop, 1'b0}) : '0;
  end

  // Hand-off is registered: channel k arms one edge after k-1 stops.
  always_ff @(posedge clk) begin
    if (reset || start || clear) arm_q <= '0;
    else                         arm_q <= chain_src;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    profiler_channel #(
      .CNT_W   (CNT_W),
      .DATA_W  (DATA_W),
      .SENTINEL(SENTINEL)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .start_arm((k == 0) || !CHAIN),
      .clear    (clear),
      .chain_arm(arm_q[k]),
      .rvalid   (rvalid[k]),
      .rdata    (rdata[k*DATA_W +: DATA_W]),
      .count    (count[k*CNT_W +: CNT_W]),
      .busy     (busy[k]),
      .done     (done[k]),
      .overflow (overflow[k]),
      .stop     (stop[k])
    );
  end

  // Registered AND of the per-channel done flags.
  always_ff @(posedge clk) begin
    if (reset || start || clear) all_done <= 1'b0;
    else                         all_done <= &done;
  end

  // End-to-end total: counts while work is running or a hand-off is in
  // flight, and stops accumulating once every channel has finished.
  always_ff @(posedge clk) begin
    if (reset) begin
      total    <= '0;
      total_en <= 1'b0;
    end else if (start) begin
      total    <= '0;
      total_en <= 1'b1;
    end else if (clear) begin
      total    <= '0;
      total_en <= 1'b0;
    end else begin
      if (total_en && (|busy || |arm_q))
        total <= CNT_W'(sat_inc(64'(total), CNT_W));
      if (&done && !all_done)
        total_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_profiler.sv
// Directed bench for stage_profiler: chained, parallel and saturating
// configurations, restart, reset and clear behaviour.
module tb_stage_profiler;

  localparam logic [31:0] SENT = 32'h7fffffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Chained, 2 channels, 32-bit counters.
  logic        c_start, c_clear;
  logic [63:0] c_rdata;
  logic [1:0]  c_rvalid;
  logic [63:0] c_count;
  logic [1:0]  c_busy, c_done, c_ovf;
  logic        c_all_done;
  logic [31:0] c_total;

  // Parallel, 3 channels.
  logic        p_start, p_clear;
  logic [95:0] p_rdata;
  logic [2:0]  p_rvalid;
  logic [95:0] p_count;
  logic [2:0]  p_busy, p_done, p_ovf;
  logic        p_all_done;
  logic [31:0] p_total;

  // Chained, 2 channels, 4-bit counters.
  logic        s_start, s_clear;
  logic [63:0] s_rdata;
  logic [1:0]  s_rvalid;
  logic [7:0]  s_count;
  logic [1:0]  s_busy, s_done, s_ovf;
  logic        s_all_done;
  logic [3:0]  s_total;

  stage_profiler #(.NUM_CH(2), .CNT_W(32), .DATA_W(32), .CHAIN(1'b1)) u_chain (
    .clk(clk), .reset(reset), .start(c_start), .clear(c_clear),
    .rdata(c_rdata), .rvalid(c_rvalid), .count(c_count), .busy(c_busy),
    .done(c_done), .overflow(c_ovf), .all_done(c_all_done), .total(c_total)
  );

  stage_profiler #(.NUM_CH(3), .CNT_W(32), .DATA_W(32), .CHAIN(1'b0)) u_par (
    .clk(clk), .reset(reset), .start(p_start), .clear(p_clear),
    .rdata(p_rdata), .rvalid(p_rvalid), .count(p_count), .busy(p_busy),
    .done(p_done), .overflow(p_ovf), .all_done(p_all_done), .total(p_total)
  );

  stage_profiler #(.NUM_CH(2), .CNT_W(4), .DATA_W(32), .CHAIN(1'b1)) u_sat (
    .clk(clk), .reset(reset), .start(s_start), .clear(s_clear),
    .rdata(s_rdata), .rvalid(s_rvalid), .count(s_count), .busy(s_busy),
    .done(s_done), .overflow(s_ovf), .all_done(s_all_done), .total(s_total)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    c_start = 1'b0; c_clear = 1'b0; c_rdata = '0; c_rvalid = '0;
    p_start = 1'b0; p_clear = 1'b0; p_rdata = '0; p_rvalid = '0;
    s_start = 1'b0; s_clear = 1'b0; s_rdata = '0; s_rvalid = '0;
    tick(2);
    check("rst_count",    c_count, 64'd0);
    check("rst_busy",     c_busy, 2'b00);
    check("rst_done",     c_done, 2'b00);
    check("rst_all_done", c_all_done, 1'b0);
    check("rst_total",    c_total, 32'd0);
    reset = 1'b0;

    // ---------------- parallel arming ----------------
    p_start = 1'b1; tick(); p_start = 1'b0;                 // edge 0
    check("par_busy0", p_busy, 3'b111);
    check("par_cnt0",  p_count, 96'd0);
    tick(2);                                                // edges 1,2
    p_rdata[64 +: 32] = SENT; p_rvalid = 3'b100;
    tick();                                                 // edge 3
    p_rdata = '0; p_rvalid = '0;
    check("par_cnt2",  p_count[64 +: 32], 32'd3);
    check("par_done3", p_done, 3'b100);
    check("par_busy3", p_busy, 3'b011);
    tick(3);                                                // edges 4..6
    p_rdata = {SENT, SENT, SENT}; p_rvalid = 3'b111;        // ch2 is DONE: ignored
    tick();                                                 // edge 7
    p_rdata = '0; p_rvalid = '0;
    check("par_cnt0_7", p_count[0 +: 32], 32'd7);
    check("par_cnt1_7", p_count[32 +: 32], 32'd7);
    check("par_cnt2_7", p_count[64 +: 32], 32'd3);
    check("par_done7",  p_done, 3'b111);
    check("par_alld7",  p_all_done, 1'b0);
    check("par_total7", p_total, 32'd7);
    tick();                                                 // edge 8
    check("par_alld8",  p_all_done, 1'b1);
    check("par_total8", p_total, 32'd7);
    tick(3);
    check("par_total_frozen", p_total, 32'd7);

    // ---------------- saturation (CNT_W=4) ----------------
    s_start = 1'b1; tick(); s_start = 1'b0;                 // edge 0
    tick(15);                                               // edge 15
    check("sat_cnt15", s_count[3:0], 4'd15);
    check("sat_ovf15", s_ovf, 2'b00);
    tick();                                                 // edge 16
    check("sat_ovf16", s_ovf, 2'b01);
    check("sat_cnt16", s_count[3:0], 4'd15);
    tick(4);                                                // edge 20
    check("sat_cnt20",   s_count[3:0], 4'd15);
    check("sat_busy20",  s_busy, 2'b01);
    check("sat_total20", s_total, 4'd15);
    s_rdata[31:0] = SENT; s_rvalid = 2'b01;
    tick();
    s_rdata = '0; s_rvalid = '0;
    check("sat_done",     s_done, 2'b01);
    check("sat_cnt_done", s_count[3:0], 4'd15);
    check("sat_ovf_held", s_ovf, 2'b01);
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("sat_ovf_restart", s_ovf, 2'b00);
    check("sat_cnt_restart", s_count, 8'd0);

    // ---------------- chained arming ----------------
    c_start = 1'b1; tick(); c_start = 1'b0;                 // edge 0
    check("ch_busy0", c_busy, 2'b01);
    tick(4);                                                // edges 1..4
    c_rdata[31:0] = SENT; c_rvalid = 2'b01;
    tick();                                                 // edge 5
    c_rdata = '0; c_rvalid = '0;
    check("ch_cnt0",   c_count[31:0], 32'd5);
    check("ch_done5",  c_done, 2'b01);
    check("ch_busy5",  c_busy, 2'b00);
    tick();                                                 // edge 6
    check("ch_busy6",  c_busy, 2'b10);
    tick(5);                                                // edges 7..11
    c_rdata[63:32] = SENT; c_rvalid = 2'b10;
    tick();                                                 // edge 12
    c_rdata = '0; c_rvalid = '0;
    check("ch_cnt1",   c_count[63:32], 32'd6);
    check("ch_done12", c_done, 2'b11);
    check("ch_alld12", c_all_done, 1'b0);
    tick();                                                 // edge 13
    check("ch_alld13",  c_all_done, 1'b1);
    check("ch_total13", c_total, 32'd12);

    // ---------------- unqualified sentinel, restart from DONE ----------------
    c_start = 1'b1; tick(); c_start = 1'b0;                 // edge 0
    check("nq_cnt0",   c_count, 64'd0);
    check("nq_total0", c_total, 32'd0);
    check("nq_done0",  c_done, 2'b00);
    c_rdata[63:32] = SENT; c_rvalid = 2'b10;                // ch1 IDLE: ignored
    tick(4);                                                // edges 1..4
    c_rdata = '0; c_rvalid = '0;
    c_rdata[31:0] = SENT;                                   // no rvalid
    tick(3);                                                // edges 5..7
    check("nq_busy7", c_busy, 2'b01);
    check("nq_done7", c_done, 2'b00);
    c_rvalid = 2'b01;
    tick();                                                 // edge 8
    c_rdata = '0; c_rvalid = '0;
    check("nq_cnt8",   c_count[31:0], 32'd8);
    check("nq_busy8",  c_busy, 2'b00);
    tick();                                                 // edge 9
    check("nq_busy9",  c_busy, 2'b10);

    // ---------------- restart while ch1 busy ----------------
    tick(2);
    c_start = 1'b1; tick(); c_start = 1'b0;
    check("rs_busy",  c_busy, 2'b01);
    check("rs_count", c_count, 64'd0);
    check("rs_done",  c_done, 2'b00);
    check("rs_ovf",   c_ovf, 2'b00);
    check("rs_total", c_total, 32'd0);
    tick();
    check("rs_total1", c_total, 32'd1);
    check("rs_cnt1",   c_count[31:0], 32'd1);

    // ---------------- reset mid-run, then clear+start ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    check("mr_count", c_count, 64'd0);
    check("mr_busy",  c_busy, 2'b00);
    check("mr_total", c_total, 32'd0);
    c_start = 1'b1; c_clear = 1'b1; tick(); c_start = 1'b0; c_clear = 1'b0;
    check("cs_busy",  c_busy, 2'b01);
    tick(3);
    check("cs_cnt3",   c_count[31:0], 32'd3);
    check("cs_total3", c_total, 32'd3);
    c_clear = 1'b1; tick(); c_clear = 1'b0;
    check("clr_busy",  c_busy, 2'b00);
    check("clr_count", c_count, 64'd0);
    check("clr_total", c_total, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
